// File: rtl/nr_div_pkg.sv
// nr_div_pkg
//   Shared constants, state encoding and the error-saturation helper for the
//   Newton-Raphson division sequencer (signed Q(6,10) operands).
package nr_div_pkg;

  localparam int FRAC            = 10;
  localparam int SEED_MANT       = 3;
  localparam int SEED_SHIFT_BASE = 18;
  localparam int MIN_LOD         = 5;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEED = 3'd1,
    LOAD = 3'd2,
    ITER = 3'd3,
    DONE = 3'd4
  } state_t;

  // Saturated quotient for a rejected denominator: zero numerator gives zero,
  // otherwise the sign of the ideal quotient picks the rail.
  function automatic logic [15:0] sat_value(input logic [15:0] nr, input logic [15:0] dr);
    logic [15:0] res;
    if (nr == 16'h0000) begin
      res = 16'h0000;
    end else if (nr[15] == dr[15]) begin
      res = SAT_POS;
    end else begin
      res = SAT_NEG;
    end
    return res;
  endfunction

endpackage

// File: rtl/nr_div_sequencer_lod16.sv
// lod16
//   Combinational leading-one detector for a 16-bit vector.
//   i_val   : vector to scan
//   o_found : 1 when any bit of i_val is set
//   o_pos   : index of the most significant set bit (0 when none)
module lod16 (
  input  logic [15:0] i_val,
  output logic        o_found,
  output logic [3:0]  o_pos
);

  // Scan upward so the highest set bit wins the last assignment.
  always_comb begin
    o_found = 1'b0;
    o_pos   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (i_val[i]) begin
        o_found = 1'b1;
        o_pos   = 4'(i);
      end else begin
        o_pos   = o_pos;
      end
    end
  end

endmodule

// File: rtl/nr_div_sequencer.sv
// nr_div_sequencer
//   Front-end controller for the Q(6,10) Newton-Raphson division core.
//   Accepts {in_nr, in_dr}, computes a reciprocal seed from |in_dr|, drives the
//   core for LOAD_CYC load cycles and ITER_CYC iteration cycles, then returns
//   the captured quotient. Denominators that are zero or too small for the seed
//   table are answered with a saturated result and out_err without using the core.
//   clk, rst_n              : clock, async active-low reset
//   in_valid/in_ready       : operand handshake (in_ready = state IDLE)
//   in_nr, in_dr            : numerator / denominator
//   div_load, div_nr, div_dr, div_guess : to the core
//   div_res                 : from the core
//   out_valid/out_ready     : result handshake
//   out_res, out_err        : quotient and error flag
module nr_div_sequencer
  import nr_div_pkg::*;
#(
  parameter int W        = 16,
  parameter int LOAD_CYC = 2,
  parameter int ITER_CYC = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_nr,
  input  logic [W-1:0] in_dr,
  output logic         div_load,
  output logic [W-1:0] div_nr,
  output logic [W-1:0] div_dr,
  output logic [W-1:0] div_guess,
  input  logic [W-1:0] div_res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_err
);

  localparam int CNT_MAX = (LOAD_CYC > ITER_CYC) ? LOAD_CYC : ITER_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LOAD_RELOAD = CW'(LOAD_CYC - 1);
  localparam logic [CW-1:0] ITER_RELOAD = CW'(ITER_CYC - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_nr;
  logic [W-1:0]  r_dr;
  logic          r_err;
  logic          r_div_load;
  logic [W-1:0]  r_div_nr;
  logic [W-1:0]  r_div_dr;
  logic [W-1:0]  r_div_guess;
  logic          r_out_valid;
  logic [W-1:0]  r_out_res;
  logic          r_out_err;

  logic [W-1:0]  w_mag;
  logic          w_found;
  logic [3:0]    w_pos;
  logic          w_err;
  logic [4:0]    w_shift;
  logic [W-1:0]  w_seed;
  logic [W-1:0]  w_guess;

  // Magnitude of the held denominator; 16'h8000 maps onto itself (p = 15).
  always_comb begin
    if (r_dr[W-1]) begin
      w_mag = ~r_dr + 16'd1;
    end else begin
      w_mag = r_dr;
    end
  end

  lod16 u_lod (
    .i_val   (w_mag),
    .o_found (w_found),
    .o_pos   (w_pos)
  );

  // Seed = 3 << (18 - p) keeps d*guess in [0.75, 1.5); sign follows the denominator.
  always_comb begin
    w_err   = !w_found || (w_pos < 4'(MIN_LOD));
    w_shift = 5'(SEED_SHIFT_BASE) - {1'b0, w_pos};
    w_seed  = 16'(SEED_MANT) << w_shift;
    if (r_dr[W-1]) begin
      w_guess = ~w_seed + 16'd1;
    end else begin
      w_guess = w_seed;
    end
  end

  // Sequencer FSM with phase counter, operand/seed registers and result registers.
  // div_load is a registered decode of LOAD, so it trails the state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_nr        <= '0;
      r_dr        <= '0;
      r_err       <= 1'b0;
      r_div_load  <= 1'b0;
      r_div_nr    <= '0;
      r_div_dr    <= '0;
      r_div_guess <= '0;
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_div_load <= (r_state == LOAD);
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_nr    <= in_nr;
            r_dr    <= in_dr;
            r_state <= SEED;
          end
        end
        SEED: begin
          r_err <= w_err;
          if (w_err) begin
            r_state <= DONE;
          end else begin
            r_div_nr    <= r_nr;
            r_div_dr    <= r_dr;
            r_div_guess <= w_guess;
            r_cnt       <= LOAD_RELOAD;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          if (r_cnt == '0) begin
            r_cnt   <= ITER_RELOAD;
            r_state <= ITER;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ITER: begin
          if (r_cnt == '0) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle captures the result; later cycles wait for the consumer.
          if (r_out_valid) begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end else begin
            r_out_valid <= 1'b1;
            r_out_err   <= r_err;
            r_out_res   <= r_err ? sat_value(r_nr, r_dr) : div_res;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign div_load  = r_div_load;
  assign div_nr    = r_div_nr;
  assign div_dr    = r_div_dr;
  assign div_guess = r_div_guess;
  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;
  assign out_err   = r_out_err;

endmodule
